// File: rtl/mprj_io_pkg.sv
// Shared constants and helpers for the mprj_io_bank GPIO pad bank.
// Default pad counts for the bank parameters.
package mprj_io_pkg;

  localparam int DEF_TOTAL_PADS = 38;
  localparam int DEF_AREA1_PADS = 19;

  localparam logic OEB_RST = 1'b1;
  localparam logic OUT_RST = 1'b0;

  // Filter counter width; must hold FILTER_CYCLES-1 without wrapping.
  function automatic int cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic int area2_count(input int total_pads, input int area1_pads);
    return total_pads - area1_pads;
  endfunction

  function automatic int area2_pad(input int area1_pads, input int j);
    return area1_pads + j;
  endfunction

endpackage

// File: rtl/mprj_io_pad_cell.sv
// One GPIO pad: registered drive with hold, 2-FF input sync, optional glitch filter
// (MPRJ_IO_FILTER_EN), and sticky rise/fall flags.
module mprj_io_pad_cell
  import mprj_io_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic io_out_i,
  input  logic oeb_i,
  input  logic holdover_i,
  input  logic inp_dis_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic edge_clr_i,
  input  logic pad_o_i,
  output logic pad_i_o,
  output logic pad_t_o,
  output logic io_in_o,
  output logic rise_flag_o,
  output logic fall_flag_o
);

  logic out_q, out_d;
  logic oeb_q, oeb_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic io_in_q, io_in_d;
  logic io_in_dly_q, io_in_dly_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic rise_set, fall_set;

`ifdef MPRJ_IO_FILTER_EN
  localparam int CNT_W = cnt_w(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    out_d       = holdover_i ? out_q : io_out_i;
    oeb_d       = holdover_i ? oeb_q : oeb_i;
    s1_d        = pad_o_i & ~inp_dis_i;
    s2_d        = s1_q;
    io_in_dly_d = io_in_q;
`ifdef MPRJ_IO_FILTER_EN
    // Accept s2 only after it has disagreed with io_in for FILTER_CYCLES cycles in a row.
    io_in_d = io_in_q;
    cnt_d   = '0;
    if (s2_q != io_in_q) begin
      if (cnt_q == CNT_LAST) io_in_d = s2_q;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
`else
    io_in_d = s2_q;
`endif
    rise_set = ~io_in_dly_q &  io_in_q & rise_en_i & ~inp_dis_i;
    fall_set =  io_in_dly_q & ~io_in_q & fall_en_i & ~inp_dis_i;
    // A new edge in the clearing cycle must not be lost, so set wins.
    rise_d   = rise_set | (rise_q & ~edge_clr_i);
    fall_d   = fall_set | (fall_q & ~edge_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= OUT_RST;
      oeb_q       <= OEB_RST;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      io_in_q     <= 1'b0;
      io_in_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
`ifdef MPRJ_IO_FILTER_EN
      cnt_q       <= '0;
`endif
    end else begin
      out_q       <= out_d;
      oeb_q       <= oeb_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      io_in_q     <= io_in_d;
      io_in_dly_q <= io_in_dly_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
`ifdef MPRJ_IO_FILTER_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign pad_i_o     = out_q;
  assign pad_t_o     = oeb_q;
  assign io_in_o     = io_in_q;
  assign rise_flag_o = rise_q;
  assign fall_flag_o = fall_q;

endmodule

// File: rtl/mprj_io_bank.sv
// User-project GPIO pad bank: per-pad cells in area-1/area-2 loops, pad buffers and irq register.
// Optional input glitch filter enabled by defining MPRJ_IO_FILTER_EN.
module mprj_io_bank
  import mprj_io_pkg::*;
#(
  parameter int TOTAL_PADS    = DEF_TOTAL_PADS,
  parameter int AREA1PADS     = DEF_AREA1_PADS,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  inout  wire  [TOTAL_PADS-1:0] io,
  input  logic [TOTAL_PADS-1:0] io_out,
  input  logic [TOTAL_PADS-1:0] oeb,
  input  logic [TOTAL_PADS-1:0] inp_dis,
  input  logic [TOTAL_PADS-1:0] holdover,
  input  logic [TOTAL_PADS-1:0] rise_en,
  input  logic [TOTAL_PADS-1:0] fall_en,
  input  logic [TOTAL_PADS-1:0] edge_clr,
  output logic [TOTAL_PADS-1:0] io_in,
  output logic [TOTAL_PADS-1:0] rise_flag,
  output logic [TOTAL_PADS-1:0] fall_flag,
  output logic                  irq
);

  localparam int AREA2PADS = area2_count(TOTAL_PADS, AREA1PADS);

  logic [TOTAL_PADS-1:0] pad_i;
  logic [TOTAL_PADS-1:0] pad_t;
  logic [TOTAL_PADS-1:0] pad_o;
  logic                  irq_q, irq_d;

  // IOBUF_INTERMDISABLE equivalent: T=1 floats the pin, IBUFDISABLE forces O low.
  for (genvar i = 0; i < TOTAL_PADS; i++) begin : g_buf
    assign io[i]    = pad_t[i] ? 1'bz : pad_i[i];
    assign pad_o[i] = ~inp_dis[i] & io[i];
  end

  for (genvar i = 0; i < AREA1PADS; i++) begin : g_area1
    mprj_io_pad_cell #(.FILTER_CYCLES(FILTER_CYCLES)) u_cell (
      .clk_i       (wb_clk_i),
      .rst_i       (wb_rst_i),
      .io_out_i    (io_out[i]),
      .oeb_i       (oeb[i]),
      .holdover_i  (holdover[i]),
      .inp_dis_i   (inp_dis[i]),
      .rise_en_i   (rise_en[i]),
      .fall_en_i   (fall_en[i]),
      .edge_clr_i  (edge_clr[i]),
      .pad_o_i     (pad_o[i]),
      .pad_i_o     (pad_i[i]),
      .pad_t_o     (pad_t[i]),
      .io_in_o     (io_in[i]),
      .rise_flag_o (rise_flag[i]),
      .fall_flag_o (fall_flag[i])
    );
  end

  for (genvar j = 0; j < AREA2PADS; j++) begin : g_area2
    localparam int P = area2_pad(AREA1PADS, j);
    mprj_io_pad_cell #(.FILTER_CYCLES(FILTER_CYCLES)) u_cell (
      .clk_i       (wb_clk_i),
      .rst_i       (wb_rst_i),
      .io_out_i    (io_out[P]),
      .oeb_i       (oeb[P]),
      .holdover_i  (holdover[P]),
      .inp_dis_i   (inp_dis[P]),
      .rise_en_i   (rise_en[P]),
      .fall_en_i   (fall_en[P]),
      .edge_clr_i  (edge_clr[P]),
      .pad_o_i     (pad_o[P]),
      .pad_i_o     (pad_i[P]),
      .pad_t_o     (pad_t[P]),
      .io_in_o     (io_in[P]),
      .rise_flag_o (rise_flag[P]),
      .fall_flag_o (fall_flag[P])
    );
  end

  assign irq_d = |(rise_flag | fall_flag);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mprj_io_bank.sv
// Directed self-checking bench for mprj_io_bank; covers both builds (MPRJ_IO_FILTER_EN on/off).
module tb_mprj_io_bank;

  localparam int N  = 12;
  localparam int A1 = 6;
  localparam int FC = 4;
`ifdef MPRJ_IO_FILTER_EN
  localparam int LAT = 2 + FC;
`else
  localparam int LAT = 3;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] io_out, oeb, inp_dis, holdover, rise_en, fall_en, edge_clr;
  logic [N-1:0] ext_en, ext_val;
  wire  [N-1:0] io;
  wire  [N-1:0] io_in, rise_flag, fall_flag;
  wire          irq;

  int checks = 0;
  int errors = 0;
  logic seen;

  mprj_io_bank #(.TOTAL_PADS(N), .AREA1PADS(A1), .FILTER_CYCLES(FC)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .io        (io),
    .io_out    (io_out),
    .oeb       (oeb),
    .inp_dis   (inp_dis),
    .holdover  (holdover),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .edge_clr  (edge_clr),
    .io_in     (io_in),
    .rise_flag (rise_flag),
    .fall_flag (fall_flag),
    .irq       (irq)
  );

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign io[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; io_out = '1; oeb = '0; inp_dis = '0; holdover = '0;
    rise_en = '0; fall_en = '0; edge_clr = '0;
    ext_en = '1; ext_val = 12'hA5C;

    // 1: reset floats every pad even with io_out=1/oeb=0 requested
    tick(3);
    chk("rst_pins_z", io, 12'hA5C);
    chk("rst_io_in", io_in, 0);
    chk("rst_rise", rise_flag, 0);
    chk("rst_fall", fall_flag, 0);
    chk("rst_irq", irq, 0);
    ext_en = '0;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("rel_drive", io, 12'hFFF);
    tick(LAT);
    chk("loopback_in", io_in, 12'hFFF);
    chk("loopback_noflag", rise_flag | fall_flag, 0);

    // 2: holdover on pad 3
    oeb = ~12'h008; io_out = 12'h008;
    tick(1);
    ext_en = ~12'h008; ext_val = '0;
    tick(1);
    chk("hold_pre", io[3], 1);
    holdover[3] = 1'b1; io_out[3] = 1'b0; oeb[3] = 1'b1;
    tick(2);
    chk("hold_frozen", io[3], 1);
    holdover[3] = 1'b0; oeb[3] = 1'b0;
    tick(1);
    chk("hold_release", io[3], 0);

    // 3: input latency on pad 5
    tick(LAT + 2);
    chk("in5_low", io_in[5], 0);
    ext_val[5] = 1'b1;
    tick(LAT - 1);
    chk("in5_early", io_in[5], 0);
    tick(1);
    chk("in5_latency", io_in[5], 1);

    // 4: glitch handling on pad 7
    rise_en[7] = 1'b1;
`ifdef MPRJ_IO_FILTER_EN
    ext_val[7] = 1'b1;
    tick(FC - 1);
    ext_val[7] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick(1);
      seen |= io_in[7] | rise_flag[7] | irq;
    end
    chk("glitch_short", seen, 0);
    ext_val[7] = 1'b1;
    tick(FC);
    ext_val[7] = 1'b0;
    seen = 1'b0;
    repeat (14) begin
      tick(1);
      seen |= io_in[7];
    end
    chk("glitch_pass", seen, 1);
    chk("glitch_fell", io_in[7], 0);
    chk("glitch_flag", rise_flag[7], 1);
`else
    ext_val[7] = 1'b1;
    tick(1);
    ext_val[7] = 1'b0;
    seen = 1'b0;
    repeat (LAT + 3) begin
      tick(1);
      seen |= io_in[7];
    end
    chk("pulse1_pass", seen, 1);
    chk("pulse1_fell", io_in[7], 0);
    chk("pulse1_flag", rise_flag[7], 1);
`endif
    rise_en[7] = 1'b0; edge_clr[7] = 1'b1;
    tick(1);
    edge_clr[7] = 1'b0;
    chk("p7_cleared", rise_flag[7], 0);
    tick(1);
    chk("p7_irq_off", irq, 0);

    // 5: flags on pad 2
    rise_en[2] = 1'b1; ext_val[2] = 1'b1;
    tick(LAT);
    chk("p2_in_rise", io_in[2], 1);
    chk("p2_flag_early", rise_flag[2], 0);
    tick(1);
    chk("p2_flag_set", rise_flag[2], 1);
    chk("p2_irq_early", irq, 0);
    tick(1);
    chk("p2_irq_set", irq, 1);
    rise_en[2] = 1'b0; ext_val[2] = 1'b0;
    tick(LAT + 2);
    chk("p2_persist", rise_flag[2], 1);
    chk("p2_no_fall", fall_flag[2], 0);
    rise_en[2] = 1'b1; ext_val[2] = 1'b1;
    tick(LAT);
    edge_clr[2] = 1'b1;
    tick(1);
    edge_clr[2] = 1'b0;
    chk("p2_set_beats_clr", rise_flag[2], 1);
    edge_clr[2] = 1'b1;
    tick(1);
    edge_clr[2] = 1'b0;
    chk("p2_lone_clr", rise_flag[2], 0);
    chk("p2_irq_lag", irq, 1);
    tick(1);
    chk("p2_irq_clear", irq, 0);
    rise_en[2] = 1'b0; fall_en[2] = 1'b1; ext_val[2] = 1'b0;
    tick(LAT + 1);
    chk("p2_fall_set", fall_flag[2], 1);
    chk("p2_rise_off", rise_flag[2], 0);
    fall_en[2] = 1'b0; edge_clr[2] = 1'b1;
    tick(1);
    edge_clr[2] = 1'b0;
    chk("p2_fall_clr", fall_flag[2], 0);
    tick(1);

    // 6: input disable on pad 9, then reset mid-operation
    inp_dis[9] = 1'b1; rise_en[9] = 1'b1; fall_en[9] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) ext_val[9] = ~ext_val[9];
      tick(1);
      seen |= io_in[9] | rise_flag[9] | fall_flag[9];
    end
    chk("p9_disabled", seen, 0);
    chk("p9_irq", irq, 0);
    rise_en[5] = 1'b1; fall_en[5] = 1'b1; ext_val[5] = 1'b0;
    tick(LAT + 2);
    chk("p5_fall_pre", fall_flag[5], 1);
    chk("p5_irq_pre", irq, 1);
    rst = 1'b1; ext_en = '1; ext_val = 12'h3C3;
    tick(1);
    chk("mid_rst_flags", rise_flag | fall_flag, 0);
    chk("mid_rst_io_in", io_in, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_pins_z", io, 12'h3C3);
    rst = 1'b0;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
